// File: rtl/i2c_target.sv
// i2c_target: I2C target endpoint with 7-bit address match and byte-wide local interface
// Ports: clk (system clock, >= 20x SCL), rst (asynchronous, active-low),
//        I2C_SCL (bus clock in), I2C_SDA (open-drain bus data, drives 0 or z only),
//        tx_data/tx_load (byte source for reads), rx_data/rx_valid (byte sink for writes),
//        addr_match, rw_dir, busy (transfer status).
// Optional: define I2C_GLITCH_FILTER_EN to add a FILTER_LEN-sample glitch filter on SCL/SDA.
module i2c_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         FILTER_LEN  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       I2C_SCL,
   inout  wire        I2C_SDA,
   input  logic [7:0] tx_data,
   output logic       tx_load,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       addr_match,
   output logic       rw_dir,
   output logic       busy
);
   localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, ADDR_ACK = 3'd2, WR_DATA = 3'd3,
                          WR_ACK = 3'd4, RD_DATA = 3'd5, RD_ACK = 3'd6, IGNORE = 3'd7;
   if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_len
      $error("FILTER_LEN must be 2..15");
   end
   // bit 1 = SCL, bit 0 = SDA
   logic [1:0] r_s1, r_s2, r_prev, w_lvl;
   logic       w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [2:0] r_state;
   logic [3:0] r_bit;
   logic [6:0] r_shift;
   logic [7:0] w_shift_in;
   logic       r_oe, r_tx_load, r_rx_valid, r_match, r_rw, r_busy;
   logic [7:0] r_rx_data;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_s1 <= '1;
         r_s2 <= '1;
         r_prev <= '1;
      end else begin
         r_s1 <= {I2C_SCL, I2C_SDA};
         r_s2 <= r_s1;
         r_prev <= w_lvl;
      end
`ifdef I2C_GLITCH_FILTER_EN
   logic [1:0]      r_flt;
   logic [1:0][3:0] r_cnt;
   // Filtered level flips only after FILTER_LEN consecutive disagreeing samples
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_flt <= '1;
         r_cnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++)
            if (r_s2[i] == r_flt[i]) r_cnt[i] <= '0;
            else if (r_cnt[i] == 4'(FILTER_LEN - 1)) begin
               r_flt[i] <= r_s2[i];
               r_cnt[i] <= '0;
            end else r_cnt[i] <= r_cnt[i] + 4'd1;
      end
   assign w_lvl = r_flt;
`else
   assign w_lvl = r_s2;
`endif
   assign w_scl_rise = w_lvl[1] & ~r_prev[1];
   assign w_scl_fall = ~w_lvl[1] & r_prev[1];
   assign w_start    = w_lvl[1] & ~w_lvl[0] & r_prev[0];
   assign w_stop     = w_lvl[1] & w_lvl[0] & ~r_prev[0];
   assign w_shift_in = {r_shift, w_lvl[0]};
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state <= IDLE;
         r_bit <= '0;
         r_shift <= '0;
         r_oe <= 1'b0;
         r_tx_load <= 1'b0;
         r_rx_data <= '0;
         r_rx_valid <= 1'b0;
         r_match <= 1'b0;
         r_rw <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_tx_load <= 1'b0;
         r_rx_valid <= 1'b0;
         if (w_start) begin
            r_state <= ADDR;
            r_bit <= '0;
            r_oe <= 1'b0;
            r_match <= 1'b0;
            r_busy <= 1'b1;
         end else if (w_stop) begin
            r_state <= IDLE;
            r_oe <= 1'b0;
            r_match <= 1'b0;
            r_busy <= 1'b0;
         end else case (r_state)
            // r_bit == 8 marks "byte complete, waiting for the falling edge"
            ADDR, WR_DATA:
               if (w_scl_rise && r_bit < 4'd8) begin
                  r_shift <= w_shift_in[6:0];
                  r_bit <= r_bit + 4'd1;
                  if (r_bit == 4'd7 && r_state == ADDR) begin
                     if (r_shift == TARGET_ADDR) r_rw <= w_lvl[0];
                     else r_state <= IGNORE;
                  end
                  if (r_bit == 4'd7 && r_state == WR_DATA) begin
                     r_rx_data <= w_shift_in;
                     r_rx_valid <= 1'b1;
                  end
               end else if (w_scl_fall && r_bit == 4'd8) begin
                  r_oe <= 1'b1;
                  r_match <= r_match | (r_state == ADDR);
                  r_state <= r_state == ADDR ? ADDR_ACK : WR_ACK;
               end
            ADDR_ACK, WR_ACK:
               if (w_scl_fall) begin
                  r_bit <= '0;
                  if (r_state == ADDR_ACK && r_rw) begin
                     r_shift <= tx_data[6:0];
                     r_tx_load <= 1'b1;
                     r_oe <= ~tx_data[7];
                     r_state <= RD_DATA;
                  end else begin
                     r_oe <= 1'b0;
                     r_state <= WR_DATA;
                  end
               end
            RD_DATA:
               if (w_scl_fall) begin
                  r_bit <= r_bit == 4'd7 ? 4'd0 : r_bit + 4'd1;
                  r_oe <= r_bit == 4'd7 ? 1'b0 : ~r_shift[6];
                  r_shift <= {r_shift[5:0], 1'b0};
                  r_state <= r_bit == 4'd7 ? RD_ACK : RD_DATA;
               end
            RD_ACK:
               if (w_scl_rise && w_lvl[0]) begin
                  r_match <= 1'b0;
                  r_state <= IGNORE;
               end else if (w_scl_rise) r_bit <= 4'd8;
               else if (w_scl_fall && r_bit == 4'd8) begin
                  r_bit <= '0;
                  r_shift <= tx_data[6:0];
                  r_tx_load <= 1'b1;
                  r_oe <= ~tx_data[7];
                  r_state <= RD_DATA;
               end
            default: ;
         endcase
      end
   assign I2C_SDA    = r_oe ? 1'b0 : 1'bz;
   assign tx_load    = r_tx_load;
   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign addr_match = r_match;
   assign rw_dir     = r_rw;
   assign busy       = r_busy;
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) endpoint; the other end of the bus from the team's I2C initiator.
- Recognises START/STOP on SCL/SDA and matches a 7-bit address. Receives write bytes and returns read bytes through a byte-wide local interface.
- Drives SDA open-drain only; never drives SCL. Sits behind the board-level I2C pins, feeding register-file or FIFO logic.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit bus address this target responds to.
- FILTER_LEN, 4, consecutive equal samples required by the optional glitch filter (range 2..15).

Ports:
- clk  input  1  system clock; must be at least 20x the SCL frequency.
- rst  input  1  asynchronous, active-low reset.
- I2C_SCL  input  1  bus clock from the initiator.
- I2C_SDA  inout  1  bus data; driven only to 0, otherwise 1'bz.
- tx_data  input  8  byte returned on the next read byte; must be stable when tx_load pulses.
- tx_load  output  1  1-cycle pulse when tx_data is copied into the shift register.
- rx_data  output  8  last byte written by the initiator.
- rx_valid  output  1  1-cycle pulse; rx_data updated on that cycle.
- addr_match  output  1  high from address ACK until STOP, START or NACK.
- rw_dir  output  1  R/W bit of the current addressed transfer (1 = read).
- busy  output  1  high from START detect to STOP detect.

Behaviour:
- Reset (rst=0):
  - state=IDLE; SDA released (z).
  - Outputs: tx_load=0, rx_data=8'h00, rx_valid=0, addr_match=0, rw_dir=0, busy=0.
  - Sync flops reset to 1.
- Input sampling and edge detect:
  - SCL and SDA each pass through a 2-FF synchroniser plus a previous-value register.
  - scl_rise/scl_fall/sda_rise/sda_fall are 1-cycle strobes, 3 clk after the pin change.
- START: sda_fall while synced SCL=1.
  - Any state -> ADDR; bit_cnt=0; SDA released; addr_match=0; busy=1.
  - Repeated START is handled identically.
- STOP: sda_rise while synced SCL=1.
  - Any state -> IDLE; SDA released; addr_match=0; busy=0.
  - START/STOP take priority over any data edge in the same cycle.
- Data timing:
  - Bits are sampled on scl_rise, MSB first.
  - The target changes SDA only on scl_fall.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift 8 bits on scl_rise. After the 8th bit:
    - If shift[7:1]==TARGET_ADDR: latch rw_dir=shift[0]; on the next scl_fall drive SDA=0 and go to ADDR_ACK.
    - Else -> IGNORE (SDA stays released).
  - ADDR_ACK: addr_match=1. Action on the 9th scl_fall:
    - Write (rw_dir=0): release SDA -> WR_DATA.
    - Read (rw_dir=1): load shift=tx_data, pulse tx_load, drive SDA=~tx_data[7]-style open-drain (0 if bit=0, z if bit=1) -> RD_DATA.
  - WR_DATA: shift 8 bits on scl_rise. On the 8th bit: rx_data<=byte and rx_valid pulses in the same cycle. On the next scl_fall drive SDA=0 -> WR_ACK.
  - WR_ACK: on scl_fall release SDA, bit_cnt=0 -> WR_DATA. Data bytes are always ACKed.
  - RD_DATA: on each scl_fall present the next bit. After the 8th bit's scl_fall, release SDA -> RD_ACK.
  - RD_ACK: sample SDA on scl_rise.
    - 0 (ACK): on the next scl_fall load tx_data, pulse tx_load, present bit 7 -> RD_DATA.
    - 1 (NACK): addr_match=0 -> IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- bit_cnt is 4 bits and resets to 0 at every byte boundary; no wrap beyond 8.
- An SCL edge while in IDLE without a START is ignored.
- Reset asserted mid-transfer releases SDA within the same cycle (asynchronous).

Optional Feature:
- Macro I2C_GLITCH_FILTER_EN.
- Defined:
  - After the synchroniser, each of SCL and SDA feeds a saturating counter.
  - The filtered level changes only after FILTER_LEN consecutive clk samples differ from the current filtered level.
  - Edge latency becomes 3+FILTER_LEN clk.
  - Pulses shorter than FILTER_LEN clk are suppressed.
- Undefined: no filter; latency 3 clk; behaviour otherwise identical.

Test Plan:
- Write to own address: START, addr 0x50 W, data 0xA5, 0x3C, STOP -> target ACKs addr and both bytes; rx_valid pulses twice with rx_data 0xA5 then 0x3C; busy falls after STOP.
- Read two bytes: START, 0x50 R, tx_data=0x96 then 0x0F, initiator ACKs byte 1 and NACKs byte 2, STOP -> SDA carries 0x96, 0x0F; tx_load pulses twice; addr_match drops after NACK.
- Wrong address: START, 0x51 W, 0xFF, STOP -> SDA never driven (NACK seen as 1); no rx_valid; addr_match stays 0.
- Repeated start: START, 0x50 W, 0x10, Sr, 0x50 R, read 1 byte with NACK, STOP -> rx_data=0x10; rw_dir goes 0 then 1; read byte equals tx_data.
- Reset mid-byte: drive rst=0 while the target drives ACK low -> SDA is z immediately; all outputs take reset values; next START and address are accepted normally.
- With I2C_GLITCH_FILTER_EN, FILTER_LEN=4: 2-clk low glitch on SDA while SCL high -> no START detected and state stays IDLE. Without the macro the same glitch is detected as START + STOP.
